// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction-fetch stage.
//   NOP_INSTR     - word presented to decode when no fetched word is available
//                   (LLB R0,#0).
//   fetch_state_e - fetch control states: RUN, HALT.
//   cnt_w()       - width of a counter that must hold 0..depth inclusive.
package if_pkg;

  localparam logic [47:0] NOP_INSTR = 48'h0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH x WIDTH FIFO holding fetched words and their
// next-PC values. The head is visible combinationally on rdata.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset (pointers/count only)
//   push, wdata  - write a word (ignored when full unless popping too)
//   pop          - remove the head (ignored when empty)
//   clear        - drop all contents; wins over push/pop
//   rdata        - head entry
//   count        - number of stored entries, 0..DEPTH
//   empty, full  - occupancy flags
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, issues word requests to a
// variable-latency in-order instruction memory, buffers responses in
// fetch_fifo and presents one instruction (or a NOP bubble) per cycle to the
// IM_ID flop. Redirects on flow_change_ID_EX, dropping wrong-path responses;
// freezes for good once a HLT reaches ID_EX.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   stall_IM_ID           - decode did not consume the presented word
//   flow_change_ID_EX     - redirect to dst_ID_EX
//   hlt_ID_EX             - stop fetching (sticky until reset)
//   im_req/im_addr/im_gnt - request handshake (word address)
//   im_rvld/im_rdata      - in-order response
//   instr/instr_vld       - word to decode, valid flag (NOP when invalid)
//   nxt_pc                - address of presented word + 1 (held when empty)
// Optional build macro IF_FETCH_PERF_EN adds perf_fetched / perf_bubbles,
// saturating 32-bit counters of accepted responses and RUN-state bubbles.
module if_fetch
  import if_pkg::*;
#(
  parameter int              PC_W    = 16,
  parameter int              INSTR_W = 48,
  parameter logic [PC_W-1:0] RST_PC  = '0,
  parameter int              DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [PC_W-1:0]    dst_ID_EX,
  input  logic               hlt_ID_EX,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_gnt,
  input  logic               im_rvld,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic [PC_W-1:0]    nxt_pc
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam int              CW      = cnt_w(DEPTH);
  localparam int              FW      = INSTR_W + PC_W;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   rsp_pc;
  logic [PC_W-1:0]   last_nxt_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     out_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              flush;
  logic              hlt_go;
  logic              grant;
  logic              rsp;
  logic              keep;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FW-1:0]     fifo_rdata;

  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
  assign flush     = flow_change_ID_EX & (state == RUN);
  assign grant     = im_req & im_gnt;
  // A response with nothing outstanding can only be a leftover from before
  // reset; ignore it so the counters never underflow.
  assign rsp       = im_rvld & (outstanding != '0);
  assign keep      = rsp & (drop_cnt == '0) & ~flush & ~hlt_go & (state == RUN);
  assign out_nxt   = outstanding + CW'(grant) - CW'(rsp);
  assign im_addr   = pc;

  // Flush has priority over HLT; requests are held off during the flush cycle.
  always_comb begin
    state_nxt = state;
    im_req    = 1'b0;
    hlt_go    = 1'b0;
    if (state == RUN) begin
      hlt_go = hlt_ID_EX & ~flow_change_ID_EX;
      im_req = rst_n & ~flow_change_ID_EX & (occupancy < DEPTH_C);
      if (hlt_go) state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // rsp_pc is the address of the next response that will be kept. Requests
  // after a redirect are contiguous from dst_ID_EX and wrong-path responses
  // are never kept, so this counter is the address queue running in step
  // with the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RST_PC;
      rsp_pc      <= RST_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_nxt_pc <= RST_PC;
    end else begin
      outstanding <= out_nxt;
      if (flush) begin
        pc     <= dst_ID_EX;
        rsp_pc <= dst_ID_EX;
      end else begin
        if (grant) pc     <= pc + PC_W'(1);
        if (keep)  rsp_pc <= rsp_pc + PC_W'(1);
      end
      // Everything still in flight after this cycle belongs to the old path.
      if (flush || hlt_go)               drop_cnt <= out_nxt;
      else if (rsp && drop_cnt != '0)    drop_cnt <= drop_cnt - CW'(1);
      if (!fifo_empty) last_nxt_pc <= fifo_rdata[PC_W-1:0];
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .wdata ({im_rdata, rsp_pc + PC_W'(1)}),
    .pop   (~stall_IM_ID),
    .clear (flush | hlt_go),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_vld = ~fifo_empty;
  assign instr     = fifo_empty ? INSTR_W'(NOP_INSTR) : fifo_rdata[FW-1:PC_W];
  assign nxt_pc    = fifo_empty ? last_nxt_pc : fifo_rdata[PC_W-1:0];

`ifdef IF_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (keep)                          perf_fetched <= sat_inc(perf_fetched);
      if (state == RUN && fifo_empty)    perf_bubbles <= sat_inc(perf_bubbles);
    end
  end
`endif

  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= DEPTH_C);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(keep && fifo_full && stall_IM_ID));

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  typedef struct {
    logic [15:0] addr;
    int          cnt;
  } mreq_t;

  typedef struct {
    logic [47:0] ins;
    logic [15:0] nxt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_IM_ID;
  logic        flow_change_ID_EX;
  logic [15:0] dst_ID_EX;
  logic        hlt_ID_EX;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_gnt;
  logic        im_rvld;
  logic [47:0] im_rdata;
  logic [47:0] instr;
  logic        instr_vld;
  logic [15:0] nxt_pc;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cyc = -1;
  int          first_vld = -1;
  int          n;
  logic        halted = 1'b0;
  logic        prev_wait = 1'b0;
  logic [15:0] exp_addr = 16'h0;
  logic [15:0] last_nxt = 16'h0;
  mreq_t       memq[$];
  exp_t        expq[$];

  if_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .hlt_ID_EX         (hlt_ID_EX),
    .im_req            (im_req),
    .im_addr           (im_addr),
    .im_gnt            (im_gnt),
    .im_rvld           (im_rvld),
    .im_rdata          (im_rdata),
    .instr             (instr),
    .instr_vld         (instr_vld),
    .nxt_pc            (nxt_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [47:0] mk(input logic [15:0] a);
    return {a ^ 16'h5A5A, 16'hC0DE, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample/check at negedge, then advance the memory model and
  // scoreboard just after posedge.
  task automatic tick();
    logic        grant_s, rv_s, fl_s, hl_s, rst_s;
    logic [15:0] addr_s;
    @(negedge clk);
    rst_s   = rst_n;
    grant_s = im_req & im_gnt;
    addr_s  = im_addr;
    rv_s    = im_rvld;
    fl_s    = flow_change_ID_EX;
    hl_s    = hlt_ID_EX & ~flow_change_ID_EX;
    if (rst_s) begin
      cyc++;
      if (halted) begin
        chk("halt_req", im_req, 1'b0);
        chk("halt_vld", instr_vld, 1'b0);
        chk("halt_instr", instr, 48'h0);
      end else begin
        if (fl_s)           chk("flush_req", im_req, 1'b0);
        else if (prev_wait) chk("req_hold", im_req, 1'b1);
        if (im_req) chk("im_addr", im_addr, exp_addr);
        if (instr_vld) begin
          if (first_vld < 0) first_vld = cyc;
          if (expq.size() == 0) chk("vld_unexpected", instr_vld, 1'b0);
          else begin
            chk("instr", instr, expq[0].ins);
            chk("nxt_pc", nxt_pc, expq[0].nxt);
            last_nxt = expq[0].nxt;
            if (!stall_IM_ID) void'(expq.pop_front());
          end
        end else begin
          chk("nop_instr", instr, 48'h0);
          chk("hold_nxt_pc", nxt_pc, last_nxt);
        end
      end
      prev_wait = im_req & ~im_gnt;
    end else begin
      prev_wait = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!rst_s) begin
      memq.delete();
      expq.delete();
      exp_addr = 16'h0;
      last_nxt = 16'h0;
      halted   = 1'b0;
      cyc      = -1;
    end else begin
      if (rv_s && memq.size() > 0) void'(memq.pop_front());
      foreach (memq[i]) if (memq[i].cnt > 0) memq[i].cnt--;
      if (grant_s) begin
        memq.push_back('{addr_s, lat - 1});
        expq.push_back('{mk(exp_addr), exp_addr + 16'd1});
        exp_addr = exp_addr + 16'd1;
      end
      if (fl_s) begin
        expq.delete();
        exp_addr = dst_ID_EX;
      end else if (hl_s) begin
        expq.delete();
        halted = 1'b1;
      end
    end
    if (memq.size() > 0 && memq[0].cnt == 0) begin
      im_rvld  = 1'b1;
      im_rdata = mk(memq[0].addr);
    end else begin
      im_rvld  = 1'b0;
      im_rdata = 48'h0;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    im_gnt      = 1'b0;
    stall_IM_ID = 1'b0;
    while ((expq.size() != 0 || memq.size() != 0) && k < 40) begin
      tick();
      k++;
    end
    chk(tag, expq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; stall_IM_ID = 1'b0; flow_change_ID_EX = 1'b0; dst_ID_EX = 16'h0;
    hlt_ID_EX = 1'b0; im_gnt = 1'b1; im_rvld = 1'b0; im_rdata = 48'h0; lat = 1;
    tick(); tick();
    #2;
    chk("rst_req", im_req, 1'b0);
    chk("rst_vld", instr_vld, 1'b0);
    chk("rst_instr", instr, 48'h0);
    chk("rst_nxt_pc", nxt_pc, 16'h0);
    rst_n = 1'b1;

    // Streaming, 1-cycle memory, no stalls.
    repeat (12) tick();
    chk("first_vld_cycle", first_vld, 2);

    // Decode stall fills the buffer and holds off requests.
    stall_IM_ID = 1'b1;
    repeat (4) tick();
    #2;
    chk("stall_req_off", im_req, 1'b0);
    chk("stall_vld", instr_vld, 1'b1);
    tick();
    stall_IM_ID = 1'b0;
    repeat (8) tick();
    drain("drain_stall");

    // Redirect with two requests outstanding.
    im_gnt = 1'b1; lat = 4; n = 0;
    while (!(memq.size() == 2 && !im_rvld) && n < 30) begin tick(); n++; end
    chk("setup_two_out", memq.size(), 2);
    flow_change_ID_EX = 1'b1; dst_ID_EX = 16'h0040;
    tick();
    flow_change_ID_EX = 1'b0; lat = 1;
    repeat (10) tick();
    drain("drain_flush");

    // Redirect in the same cycle as a response.
    im_gnt = 1'b1; lat = 2; n = 0;
    while (!(im_rvld && memq.size() == 2) && n < 30) begin tick(); n++; end
    chk("setup_rv_flush", memq.size(), 2);
    flow_change_ID_EX = 1'b1; dst_ID_EX = 16'h0100;
    tick();
    flow_change_ID_EX = 1'b0;
    repeat (10) tick();
    drain("drain_rv_flush");

    // PC wrap-around.
    im_gnt = 1'b1; lat = 1;
    flow_change_ID_EX = 1'b1; dst_ID_EX = 16'hFFFE;
    tick();
    flow_change_ID_EX = 1'b0;
    repeat (10) tick();
    drain("drain_wrap");

    // Random stalls, grants, latencies and redirects.
    repeat (80) begin
      stall_IM_ID       = ($urandom_range(0, 2) == 0);
      im_gnt            = ($urandom_range(0, 3) != 0);
      lat               = $urandom_range(1, 3);
      flow_change_ID_EX = ($urandom_range(0, 15) == 0);
      dst_ID_EX         = 16'($urandom);
      tick();
    end
    flow_change_ID_EX = 1'b0;
    drain("drain_random");

    // HLT freezes fetch until reset.
    im_gnt = 1'b1; lat = 2;
    repeat (4) tick();
    hlt_ID_EX = 1'b1;
    tick();
    hlt_ID_EX = 1'b0;
    repeat (100) tick();

    rst_n = 1'b0;
    tick(); tick();
    #2;
    chk("rst2_req", im_req, 1'b0);
    chk("rst2_vld", instr_vld, 1'b0);
    chk("rst2_nxt_pc", nxt_pc, 16'h0);
    rst_n = 1'b1; im_gnt = 1'b1; lat = 1;
    repeat (10) tick();
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: owns the PC, issues requests to a variable-latency instruction memory, and buffers returned words in a small FIFO.
- Each cycle it presents one 48-bit instruction, or a bubble, to the decode stage's IM_ID flop.
- Redirects the PC on flow_change_ID_EX and discards wrong-path responses.
- Freezes permanently once a HLT reaches ID_EX.

Parameters:
- PC_W, 16, PC / instruction-word address width (word addressed, +1 per instruction).
- INSTR_W, 48, instruction width.
- RST_PC, 0, PC value after reset.
- DEPTH, 2, maximum of (outstanding requests + buffered instructions), power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- stall_IM_ID  in  1  decode stall; the presented instruction is not consumed this cycle.
- flow_change_ID_EX  in  1  taken branch/jump resolved; redirect.
- dst_ID_EX  in  PC_W  redirect target.
- hlt_ID_EX  in  1  HLT in ID_EX; stop fetching.
- im_req  out  1  request valid.
- im_addr  out  PC_W  request word address.
- im_gnt  in  1  memory accepts request this cycle.
- im_rvld  in  1  response valid; responses return in request order.
- im_rdata  in  INSTR_W  response data.
- instr  out  INSTR_W  instruction to decode; 48'h0 (LLB R0,#0 NOP) when no valid word.
- instr_vld  out  1  instr holds a real fetched word.
- nxt_pc  out  PC_W  address of presented instruction + 1 (feeds NPC2SRC1 path).

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc=RST_PC; FIFO empty; outstanding=0; drop_cnt=0; state=RUN.
  - Outputs: im_req=0, instr=0, instr_vld=0, nxt_pc=RST_PC.
  - Reset mid-transaction abandons in-flight responses. Memory must also be reset; no response may arrive in the first cycle after reset.
- States:
  - RUN → HALT on hlt_ID_EX.
  - HALT is sticky until reset.
  - No other states; redirects are handled inside RUN.
- Request issue:
  - im_req=1 in RUN when (outstanding + fifo_count) < DEPTH and no flush this cycle.
  - im_addr=pc.
  - On im_req & im_gnt: pc<=pc+1 (wraps mod 2^PC_W), outstanding++.
  - im_req and im_addr stay stable while im_req=1 and !im_gnt.
- Response:
  - On im_rvld: outstanding--.
  - If drop_cnt>0: drop_cnt-- and discard the data.
  - Otherwise push {data, addr+1} into the FIFO; the response addr is tracked by a parallel address queue.
- Present to decode:
  - FIFO head drives instr/nxt_pc and instr_vld=1.
  - Pop when !stall_IM_ID.
  - Empty FIFO drives instr=0, instr_vld=0, nxt_pc=last valid nxt_pc.
  - Zero-latency bypass is not allowed: a response appears on instr the cycle after im_rvld.
- Flush (flow_change_ID_EX=1):
  - pc<=dst_ID_EX; FIFO cleared.
  - drop_cnt <= outstanding after this cycle's grant/response accounting.
  - im_req forced 0 that cycle; requests from the new pc start the next cycle.
  - A response in the same cycle as the flush is discarded.
  - A grant in the same cycle as the flush cannot occur, because im_req=0.
- HALT:
  - Entered on hlt_ID_EX (flush wins if both are asserted).
  - im_req=0; FIFO cleared; instr=0, instr_vld=0; outstanding responses are dropped.
- Counters:
  - outstanding and fifo_count are $clog2(DEPTH)+1 bits.
  - Sum never exceeds DEPTH; assert this in simulation.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetched[31:0] (count of im_rvld responses accepted into the FIFO).
  - Adds perf_bubbles[31:0] (cycles with instr_vld=0 in RUN).
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: ports and logic are absent.

Decomposition:
- Shared package if_pkg:
  - NOP_INSTR = 48'h0.
  - State enum {RUN, HALT}.
  - Width helper for counters.
- One natural sub-module: fetch_fifo, a synchronous DEPTH×(INSTR_W+PC_W) FIFO with push/pop/clear, count, empty/full.

Test Plan:
- Reset with RST_PC=0, im_gnt=1, 1-cycle latency, no stalls → im_addr 0,1,2,… on consecutive cycles; instr_vld=1 from cycle 3; nxt_pc = addr+1.
- stall_IM_ID held 4 cycles with DEPTH=2 → after 2 fills im_req=0; instr frozen; no word lost or duplicated on release.
- Two requests outstanding, flow_change_ID_EX with dst_ID_EX=16'h0040 → both old responses dropped; next im_addr=0x40; first instr_vld carries word 0x40 with nxt_pc=0x41.
- im_rvld coincident with flow_change_ID_EX → that response discarded; drop_cnt accounts only for the remaining outstanding request.
- hlt_ID_EX pulse → im_req stays 0 for 100 cycles; instr=0, instr_vld=0 until rst_n low.
- pc=16'hFFFF fetched → next im_addr=16'h0000; nxt_pc of that instruction = 16'h0000.
